sample_timestamp_gen: RTL and testbench
=======================================

// Module: sample_timestamp_gen
// PURPOSE
//  Timestamp source in the ADC sample clock domain. Counts every valid ADC sample and frames the stream into
//  packets of PACKET_SAMPLES samples. Latches the sample count of each packet's first sample into a held
//  register, which the CDC freeze/sync stage carries into the DMA clock domain for the packer to prepend.
//  Enforces the minimum hold time that the CDC stage needs and flags packets whose timestamp could not be held.
// PARAMETERS
//  TS_WIDTH         64  width of the sample counter and the timestamp output
//  PACKET_SAMPLES   256 samples per packet, >=2
//  MIN_HOLD_CYCLES  8   minimum clk cycles ts_out is held stable after an update, >=1
// PORTS
//  clk          in   1         ADC sample-domain clock
//  rst          in   1         asynchronous reset, active-high
//  enable       in   1         capture enable; packet framing is active only while high
//  sample_valid in   1         one ADC sample accepted this cycle
//  load_strobe  in   1         (TIMESTAMP_LOAD_EN only) load the counter from load_value
//  load_value   in   TS_WIDTH  (TIMESTAMP_LOAD_EN only) new counter value
//  count_out    out  TS_WIDTH  live sample counter
//  packet_start out  1         registered; high for 1 cycle after the first sample of each packet is accepted
//  ts_out       out  TS_WIDTH  held timestamp, drives the bits_in input of the CDC sync stage
//  ts_valid     out  1         1-cycle pulse when ts_out updates
//  ts_overrun   out  1         sticky; a packet start arrived while the hold was still active
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pkt_cnt 0, hold_cnt 0.
//  Counter: increments by 1 on every sample_valid in all states, including IDLE. Wraps modulo 2^TS_WIDTH
//   (all-ones+1 -> 0, no flag). The value before the increment is that sample's timestamp.
//  FSM states:
//   IDLE: pkt_cnt=0. enable=1 -> ARM.
//   ARM: the next sample_valid is a packet start -> RUN, pkt_cnt<=1.
//   RUN: on each sample_valid, pkt_cnt<=pkt_cnt+1. When pkt_cnt==PACKET_SAMPLES-1 and sample_valid, pkt_cnt
//    wraps to 0. The sample accepted with pkt_cnt==0 is a packet start.
//   Any state: enable=0 -> IDLE on the next edge. A packet in progress is abandoned and ts_overrun is cleared.
//    ts_out keeps its value and hold_cnt keeps counting down. enable low in the same cycle as sample_valid:
//    that sample is counted but not framed.
//  Packet start (sample accepted while in ARM, or in RUN with pkt_cnt==0):
//   - If hold_cnt==0: ts_out<=sample timestamp; ts_valid=1 and packet_start=1 on the next cycle (latency 1);
//     hold_cnt<=MIN_HOLD_CYCLES.
//   - If hold_cnt!=0: ts_out is unchanged, no ts_valid, ts_overrun<=1 (sticky until IDLE or rst).
//     packet_start still pulses.
//  hold_cnt decrements by 1 each clk while nonzero. ts_out is never changed while hold_cnt!=0.
//  Mid-operation reset (rst asserted): immediate return to the reset values, including the counter.
// CONFIGURATION
//  TIMESTAMP_LOAD_EN defined:
//   - load_strobe and load_value ports exist.
//   - load_strobe=1 sets the counter to load_value; that cycle's sample (if any) has timestamp load_value and
//     the counter then becomes load_value+1. Load wins over increment.
//   - Framing and pkt_cnt are unaffected by a load.
//  Undefined: the ports are absent and the counter is changed only by rst and sample_valid.
// TESTING
//  1. rst, enable=1, 600 consecutive sample_valid -> ts_valid pulses with ts_out=0, 256, 512; packet_start
//     1 cycle after samples 0, 256, 512.
//  2. 10 samples with enable=0, then enable=1 and samples -> first ts_out=10; count_out keeps counting
//     while enable=0.
//  3. PACKET_SAMPLES=2, MIN_HOLD_CYCLES=8, sample_valid every cycle -> the second packet start (ts 2) is
//     dropped with ts_overrun=1 and ts_out=0 held for 8 cycles; then enable=0 -> ts_overrun=0.
//  4. TIMESTAMP_LOAD_EN: load all-ones-1 while idle, then 3 samples -> timestamps FF..FE, FF..FF, 0;
//     load_strobe with sample_valid -> that sample's timestamp = load_value.
//  5. rst asserted mid-packet at pkt_cnt=100 -> all outputs 0 asynchronously; after release with enable=1,
//     the next sample gives ts_out=0.

Source files
------------

// File: rtl/sample_timestamp_gen.sv
// rtl/sample_timestamp_gen.sv - ADC-domain sample counter, packet framer and held timestamp source
// Optional feature macro: TIMESTAMP_LOAD_EN (adds load_strobe/load_value counter preload)
module sample_timestamp_gen #(
    parameter int TS_WIDTH        = 64,
    parameter int PACKET_SAMPLES  = 256,
    parameter int MIN_HOLD_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                sample_valid,
`ifdef TIMESTAMP_LOAD_EN
    input  logic                load_strobe,
    input  logic [TS_WIDTH-1:0] load_value,
`endif
    output logic [TS_WIDTH-1:0] count_out,
    output logic                packet_start,
    output logic [TS_WIDTH-1:0] ts_out,
    output logic                ts_valid,
    output logic                ts_overrun
);

    localparam int PKT_W  = $clog2(PACKET_SAMPLES);
    localparam int HOLD_W = $clog2(MIN_HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PKT_W-1:0]    pkt_cnt, pkt_cnt_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TS_WIDTH-1:0] count;
    logic [TS_WIDTH-1:0] sample_ts;
    logic                load_now;
    logic                pkt_start;
    logic                hold_free;

    // A load replaces the counter before this cycle's sample is stamped.
`ifdef TIMESTAMP_LOAD_EN
    assign load_now  = load_strobe;
    assign sample_ts = load_strobe ? load_value : count;
`else
    assign load_now  = 1'b0;
    assign sample_ts = count;
`endif

    assign count_out = count;
    assign hold_free = (hold_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (sample_valid) begin
            count <= sample_ts + TS_WIDTH'(1);
        end else if (load_now) begin
            count <= sample_ts;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pkt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pkt_cnt <= pkt_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pkt_cnt_nxt = pkt_cnt;
        pkt_start   = 1'b0;
        if (!enable) begin
            state_nxt   = IDLE;
            pkt_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM: begin
                    if (sample_valid) begin
                        pkt_start   = 1'b1;
                        state_nxt   = RUN;
                        pkt_cnt_nxt = PKT_W'(1);
                    end
                end
                RUN: begin
                    if (sample_valid) begin
                        pkt_start   = (pkt_cnt == '0);
                        pkt_cnt_nxt = (pkt_cnt == PKT_W'(PACKET_SAMPLES - 1)) ? '0
                                                                              : pkt_cnt + PKT_W'(1);
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    pkt_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ts_out only moves when the CDC hold window has fully expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            packet_start <= 1'b0;
            ts_valid     <= 1'b0;
            ts_out       <= '0;
            hold_cnt     <= '0;
            ts_overrun   <= 1'b0;
        end else begin
            packet_start <= pkt_start;
            ts_valid     <= pkt_start && hold_free;
            if (pkt_start && hold_free) begin
                ts_out   <= sample_ts;
                hold_cnt <= HOLD_W'(MIN_HOLD_CYCLES);
            end else if (!hold_free) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (!enable) begin
                ts_overrun <= 1'b0;
            end else if (pkt_start && !hold_free) begin
                ts_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_timestamp_gen.sv
// tb/tb_sample_timestamp_gen.sv - scoreboard bench for sample_timestamp_gen (two framing configurations)
module tb_sample_timestamp_gen;

    localparam int TW   = 64;
    localparam int HOLD = 8;

    typedef struct {
        logic [TW-1:0] ts;
        logic          valid;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic          load_strobe = 1'b0;
    logic [TW-1:0] load_value = '0;

    logic [TW-1:0] cnt_o [2];
    logic [TW-1:0] ts_o  [2];
    logic          ps_o  [2];
    logic          tv_o  [2];
    logic          ov_o  [2];

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sample_timestamp_gen #(
            .TS_WIDTH       (TW),
            .PACKET_SAMPLES ((g == 0) ? 256 : 2),
            .MIN_HOLD_CYCLES(HOLD)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .sample_valid(sample_valid),
`ifdef TIMESTAMP_LOAD_EN
            .load_strobe (load_strobe),
            .load_value  (load_value),
`endif
            .count_out   (cnt_o[g]),
            .packet_start(ps_o[g]),
            .ts_out      (ts_o[g]),
            .ts_valid    (tv_o[g]),
            .ts_overrun  (ov_o[g])
        );
    end

    // Reference model: framed-sample index, hold window measured in clock edges.
    exp_t          q0[$], q1[$];
    logic [TW-1:0] m_count;
    logic [TW-1:0] m_ts     [2];
    bit            m_ovr    [2];
    bit            m_active [2];
    int            m_nfr    [2];
    int            m_last   [2];
    int            m_edge;

    function automatic int ps(input int i);
        return (i == 0) ? 256 : 2;
    endfunction

    task automatic push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic model_reset();
        m_count = '0;
        m_edge  = 0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_ts[i]     = '0;
            m_ovr[i]    = 1'b0;
            m_active[i] = 1'b0;
            m_nfr[i]    = 0;
            m_last[i]   = -1000;
        end
    endtask

    task automatic model_edge();
        logic [TW-1:0] ts;
        exp_t          e;
        m_edge++;
        ts      = load_strobe ? load_value : m_count;
        m_count = sample_valid ? ts + 64'd1 : ts;
        for (int i = 0; i < 2; i++) begin
            if (!enable) begin
                m_active[i] = 1'b0;
                m_nfr[i]    = 0;
                m_ovr[i]    = 1'b0;
            end else if (!m_active[i]) begin
                m_active[i] = 1'b1;
            end else if (sample_valid) begin
                if (m_nfr[i] % ps(i) == 0) begin
                    if (m_edge - m_last[i] > HOLD) begin
                        m_ts[i]   = ts;
                        m_last[i] = m_edge;
                        e = '{ts: ts, valid: 1'b1};
                    end else begin
                        m_ovr[i] = 1'b1;
                        e = '{ts: m_ts[i], valid: 1'b0};
                    end
                    push(i, e);
                end
                m_nfr[i]++;
            end
        end
    endtask

    task automatic check(input string nm, input int i, input logic [TW-1:0] got, input logic [TW-1:0] want);
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", nm, i, $time, got, want);
        end
    endtask

    task automatic flag_fail(input string nm, input int i);
        vecs++;
        miss++;
        $display("FAIL %s[%0d] at %0t: got event, want none/other", nm, i, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            check("count_out", i, cnt_o[i], m_count);
            check("ts_out", i, ts_o[i], m_ts[i]);
            check("ts_overrun", i, 64'(ov_o[i]), 64'(m_ovr[i]));
            if (ps_o[i]) begin
                if (qsize(i) == 0) begin
                    flag_fail("unexpected_packet_start", i);
                end else begin
                    e = qpop(i);
                    check("pkt_ts_out", i, ts_o[i], e.ts);
                    check("pkt_ts_valid", i, 64'(tv_o[i]), 64'(e.valid));
                end
            end else begin
                check("ts_valid_quiet", i, 64'(tv_o[i]), 64'd0);
                if (qsize(i) != 0) begin
                    void'(qpop(i));
                    flag_fail("missing_packet_start", i);
                end
            end
        end
    end

    task automatic cyc(input bit en, input bit sv, input bit ld, input logic [TW-1:0] lv);
        enable       = en;
        sample_valid = sv;
`ifdef TIMESTAMP_LOAD_EN
        load_strobe  = ld;
        load_value   = lv;
`else
        load_strobe  = 1'b0;
        load_value   = (ld) ? lv : '0;
`endif
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_count", i, cnt_o[i], 64'd0);
            check("rst_ts", i, ts_o[i], 64'd0);
            check("rst_flags", i, {61'd0, ps_o[i], tv_o[i], ov_o[i]}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit en;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Continuous stream from reset, then a quick re-arm inside the hold window.
        cyc(1, 0, 0, '0);
        repeat (600) cyc(1, 1, 0, '0);
        cyc(0, 0, 0, '0);
        cyc(1, 0, 0, '0);
        repeat (3) cyc(1, 1, 0, '0);
        cyc(0, 1, 0, '0);
        repeat (12) cyc(0, 0, 0, '0);

        // Samples counted while disabled; first framed timestamp is 10.
        do_reset();
        repeat (10) cyc(0, 1, 0, '0);
        cyc(1, 0, 0, '0);
        repeat (300) cyc(1, 1, 0, '0);
        cyc(0, 0, 0, '0);

`ifdef TIMESTAMP_LOAD_EN
        do_reset();
        cyc(1, 0, 1, {{(TW-1){1'b1}}, 1'b0});
        repeat (3) cyc(1, 1, 0, '0);
        cyc(1, 1, 1, 64'h0123_4567_89ab_cdef);
        repeat (20) cyc(1, 1, 0, '0);
        cyc(0, 0, 0, '0);
        repeat (10) cyc(0, 0, 0, '0);
        cyc(1, 0, 0, '0);
        cyc(1, 1, 1, 64'h0000_0000_dead_beef);
        repeat (5) cyc(1, 1, 0, '0);
`endif

        // Asynchronous reset in the middle of a packet.
        do_reset();
        cyc(1, 0, 0, '0);
        repeat (100) cyc(1, 1, 0, '0);
        do_reset();
        cyc(1, 0, 0, '0);
        repeat (4) cyc(1, 1, 0, '0);

        // Randomized enable/sample/load traffic.
        en = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            cyc(en, ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0),
                {$urandom, $urandom});
        end
        repeat (3) cyc(0, 0, 0, '0);

        for (int i = 0; i < 2; i++) begin
            vecs++;
            if (qsize(i) != 0) begin
                miss++;
                $display("FAIL drain[%0d]: got %0d pending want 0", i, qsize(i));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
